syn_curr_scheduler: RTL

Time-multiplexed synaptic-current controller. It sequences one shared current-update datapath (weight add on spike, decay multiply otherwise) across `N_CH` synapse channels once per simulation time step. The block holds the per-channel current state and the weight register file. It arbitrates a single external multiplier through a start/done handshake and streams each updated current to the downstream neuron integrator.

---
 rtl/syn_curr_scheduler_if.sv | 26 ++
 rtl/syn_curr_scheduler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/syn_curr_scheduler_if.sv
// rtl/syn_curr_scheduler_if.sv - multiplier handshake and current output stream of the synaptic-current scheduler
interface syn_curr_scheduler_if #(
    parameter int N_CH = 8,
    parameter int W    = 18
);
    localparam int CW = $clog2(N_CH);

    logic          mul_start;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [W-1:0]  mul_product;
    logic          mul_done;
    logic [W-1:0]  i_out;
    logic [CW-1:0] i_ch;
    logic          i_valid;

    modport master (
        output mul_start, mul_a, mul_b, i_out, i_ch, i_valid,
        input  mul_product, mul_done
    );

    modport slave (
        input  mul_start, mul_a, mul_b, i_out, i_ch, i_valid,
        output mul_product, mul_done
    );
endinterface

// File: rtl/syn_curr_scheduler.sv
// rtl/syn_curr_scheduler.sv - time-multiplexed synaptic-current update sequencer (weight add / shared-multiplier decay)
module syn_curr_scheduler #(
    parameter int           N_CH  = 8,
    parameter int           W     = 18,
    parameter logic [W-1:0] DECAY = W'(169)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    tick,
    input  logic [N_CH-1:0]         spike_in,
    input  logic                    w_we,
    input  logic [$clog2(N_CH)-1:0] w_addr,
    input  logic [W-1:0]            w_data,
    syn_curr_scheduler_if.master    bus,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);
    localparam int CW = $clog2(N_CH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_ADD      = 3'd2;
    localparam logic [2:0] S_MUL_REQ  = 3'd3;
    localparam logic [2:0] S_MUL_WAIT = 3'd4;
    localparam logic [2:0] S_WRITE    = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]      state;
    logic [CW-1:0]   ch;
    logic [N_CH-1:0] spk_q;
    logic [W-1:0]    cur [N_CH];
    logic [W-1:0]    wt  [N_CH];
    logic [W-1:0]    cur_q;
    logic [W-1:0]    wt_q;

    logic            mul_start_q;
    logic [W-1:0]    mul_a_q;
    logic [W-1:0]    mul_b_q;
    logic [W-1:0]    i_out_q;
    logic [CW-1:0]   i_ch_q;
    logic            i_valid_q;

    logic [W:0]      sum;
    logic            wr_go;
    logic [W-1:0]    wr_data;

    assign bus.mul_start = mul_start_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.i_out     = i_out_q;
    assign bus.i_ch      = i_ch_q;
    assign bus.i_valid   = i_valid_q;

    // Result selection for the three paths that end in WRITE
    always_comb begin
        sum     = {1'b0, cur_q} + {1'b0, wt_q};
        wr_go   = 1'b0;
        wr_data = '0;
        case (state)
            S_FETCH:    wr_go = !spk_q[ch] && (cur[ch] == '0);
            S_ADD: begin
                wr_go   = 1'b1;
                wr_data = sum[W] ? '1 : sum[W-1:0];
            end
            S_MUL_WAIT: begin
                wr_go   = bus.mul_done;
                wr_data = bus.mul_product;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ch          <= '0;
            spk_q       <= '0;
            cur_q       <= '0;
            wt_q        <= '0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            i_out_q     <= '0;
            i_ch_q      <= '0;
            i_valid_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cur[i] <= '0;
                wt[i]  <= '0;
            end
        end else begin
            mul_start_q <= 1'b0;
            i_valid_q   <= 1'b0;
            done        <= 1'b0;

            if (tick && busy)
                overrun <= 1'b1;
            if (w_we)
                wt[w_addr] <= w_data;

            // Abort leaves already-written channels updated; a pending mul_done lands in IDLE and is dropped
            if (state != S_IDLE && !enable) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (tick && enable) begin
                            spk_q <= spike_in;
                            ch    <= '0;
                            busy  <= 1'b1;
                            state <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        cur_q <= cur[ch];
                        wt_q  <= wt[ch];
                        if (spk_q[ch]) begin
                            state <= S_ADD;
                        end else if (cur[ch] != '0) begin
                            state       <= S_MUL_REQ;
                            mul_start_q <= 1'b1;
                            mul_a_q     <= cur[ch];
                            mul_b_q     <= DECAY;
                        end
                    end
                    S_MUL_REQ: state <= S_MUL_WAIT;
                    S_WRITE: begin
                        if (ch == CW'(N_CH - 1)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            ch    <= ch + CW'(1);
                            state <= S_FETCH;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: ;
                endcase

                if (wr_go) begin
                    cur[ch]   <= wr_data;
                    i_out_q   <= wr_data;
                    i_ch_q    <= ch;
                    i_valid_q <= 1'b1;
                    state     <= S_WRITE;
                end
            end
        end
    end
endmodule
